alu8_op_sequencer: RTL

//  Sequences the shared 8-bit ALU (alu8) from a byte-wide command stream.
//  - A command is an opcode byte, an optional A byte and a B byte.
//  - The block drives the registered ALU operands and control, then captures Result and flags.
//  - It returns them over a valid/ready response port and keeps an accumulator for chained operations.
//  - It sits between the pin-level byte interface and the alu8 instance.

---
 rtl/alu8_op_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/alu8_op_sequencer.sv
// Byte-stream command sequencer for the shared alu8: collects opcode/A/B bytes,
// drives registered ALU operands, captures the result and returns it over valid/ready.
module alu8_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_data,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [7:0]       alu_result,
  input  logic [3:0]       alu_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [3:0]       res_flags,
  output logic [7:0]       acc,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] S_OP  = 3'd0;
  localparam logic [2:0] S_A   = 3'd1;
  localparam logic [2:0] S_B   = 3'd2;
  localparam logic [2:0] S_EX  = 3'd3;
  localparam logic [2:0] S_RSP = 3'd4;

  localparam logic [CNT_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);

  logic [2:0]       state;
  logic [CNT_W-1:0] tcnt;
  logic             cmd_acc;
  logic             in_get;
  logic             tmo_hit;

  // Handshake outputs decode from state only; rst gating keeps both low during reset.
  assign cmd_ready = !rst && ((state == S_OP) || (state == S_A) || (state == S_B));
  assign res_valid = !rst && (state == S_RSP);
  assign busy      = (state != S_OP);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign in_get    = (state == S_A) || (state == S_B);
  // An accepted byte in the final idle cycle takes priority over the abort.
  assign tmo_hit   = TMO_EN && in_get && !cmd_acc && (tcnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_OP;
      tcnt        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= '0;
      res_data    <= '0;
      res_flags   <= '0;
      acc         <= '0;
      timeout_err <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        S_OP: begin
          if (cmd_acc) begin
            alu_ctrl    <= cmd_data[2:0];
            timeout_err <= 1'b0;
            tcnt        <= '0;
            if (cmd_data[3]) begin
              alu_a <= acc;
              state <= S_B;
            end else begin
              state <= S_A;
            end
          end
        end
        S_A, S_B: begin
          if (cmd_acc) begin
            tcnt <= '0;
            if (state == S_A) begin
              alu_a <= cmd_data;
              state <= S_B;
            end else begin
              alu_b <= cmd_data;
              state <= S_EX;
            end
          end else if (tmo_hit) begin
            tcnt        <= '0;
            timeout_err <= 1'b1;
            state       <= S_OP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_EX: begin
          // alu8 operands have been stable since the B accept; sample its outputs here.
          res_data  <= alu_result;
          res_flags <= alu_flags;
          acc       <= alu_result;
          op_count  <= op_count + 1'b1;
          state     <= S_RSP;
        end
        S_RSP: begin
          if (res_valid && res_ready) state <= S_OP;
        end
        default: state <= S_OP;
      endcase
    end
  end

endmodule
